// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode and FSM encodings,
// plus opcode classification helpers.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the unsigned core on the {acc, q} pair: shift-add for multiply,
// restoring trial-subtract for divide. Purely combinational.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_acc   = i_acc;
    o_q     = i_q;
    w_sum   = '0;
    w_shift = '0;
    w_diff  = '0;
    w_ge    = 1'b0;
    if (!i_div) begin
      w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});
      o_acc = w_sum[WIDTH:1];
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    end else begin
      w_shift = {i_acc, i_q[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_m};
      // A set top bit means shifted remainder >= 2^WIDTH > divisor; else use the borrow.
      w_ge    = w_shift[WIDTH] | ~w_diff[WIDTH];
      o_acc   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_q     = {i_q[WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO access.
// Magnitudes run through an unsigned core for WIDTH cycles; signs are restored in FIX.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  md_state_e          r_state, w_state_nxt;
  md_op_e             w_op;
  logic               w_launch, w_finish;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc, r_q, r_m;
  logic [WIDTH-1:0]   w_acc_nxt, w_q_nxt;
  logic               r_div, r_sx, r_sy, r_dz;
  logic               w_sx, w_sy;
  logic [WIDTH-1:0]   w_abs_x, w_abs_y;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  assign w_op    = md_op_e'(md_op);
  assign w_sx    = op_is_signed(w_op) & op_x[WIDTH-1];
  assign w_sy    = op_is_signed(w_op) & op_y[WIDTH-1];
  assign w_abs_x = w_sx ? -op_x : op_x;
  assign w_abs_y = w_sy ? -op_y : op_y;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      MD_IDLE: if (start && !flush) begin
        w_state_nxt = MD_RUN;
        w_launch    = 1'b1;
      end
      MD_RUN:  if (flush)                w_state_nxt = MD_IDLE;
               else if (r_cnt == LAST_CNT) w_state_nxt = MD_FIX;
      MD_FIX: begin
        w_state_nxt = MD_IDLE;
        w_finish    = !flush;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt)
  );

  // NOTE: the working datapath is always loaded on launch before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_acc <= '0;
      r_q   <= w_abs_x;
      r_m   <= w_abs_y;
      r_div <= op_is_div(w_op);
      r_sx  <= w_sx;
      r_sy  <= w_sy;
      r_dz  <= op_is_div(w_op) && (op_y == '0);
      r_cnt <= '0;
    end else if (r_state == MD_RUN) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Divide by zero leaves acc = |op_x|, so the remainder sign fix restores raw op_x into HI.
  assign w_prod = {r_acc, r_q};
  always_comb begin
    w_fix_hi = r_acc;
    w_fix_lo = r_q;
    if (!r_div) begin
      {w_fix_hi, w_fix_lo} = (r_sx ^ r_sy) ? -w_prod : w_prod;
    end else begin
      w_fix_lo = r_dz ? '1 : ((r_sx ^ r_sy) ? -r_q : r_q);
      w_fix_hi = r_sx ? -r_acc : r_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_dbz  <= w_finish && r_dz;
      if (w_finish) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (r_state == MD_IDLE && !start) begin
        if (mthi) r_hi <= op_x;
        if (mtlo) r_lo <= op_x;
      end
    end
  end

  assign busy        = (r_state != MD_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected HI/LO/flag pushed at launch, popped on done.
module tb_mips_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, mthi, mtlo, flush;
  logic [1:0]   md_op;
  logic [W-1:0] op_x, op_y;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .md_op       (md_op),
    .op_x        (op_x),
    .op_y        (op_y),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t               e;
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]     up;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    case (op)
      2'd0: begin sp = $signed(x) * $signed(y); {e.hi, e.lo} = sp; end
      2'd1: begin up = {{W{1'b0}}, x} * {{W{1'b0}}, y}; {e.hi, e.lo} = up; end
      default: begin
        if (y == '0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else if (op == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else if (op == 2'd2) begin
          e.lo = $signed(x) / $signed(y);
          e.hi = $signed(x) % $signed(y);
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic with_mt);
    @(negedge clk);
    md_op = op; op_x = x; op_y = y;
    start = 1'b1; mthi = with_mt; mtlo = with_mt;
    sb_q.push_back(model(op, x, y));
  endtask

  task automatic wait_result(input string name, input int spur_at, output int busy_cycles);
    exp_t e;
    bit   seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = (i == spur_at);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      if (i == spur_at) begin
        md_op = 2'($urandom_range(0, 3)); op_x = $urandom; op_y = $urandom;
      end
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s: done with empty scoreboard hi=%h lo=%h", name, hi, lo);
        end else begin
          e = sb_q.pop_front();
          if (hi !== e.hi || lo !== e.lo) begin
            failures++;
            $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
          end
          checks++;
          if (div_by_zero !== e.dbz) begin
            failures++;
            $display("FAIL %s_dbz: got %b expected %b", name, div_by_zero, e.dbz);
          end
        end
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected done=1", name);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL %s_pulse: done=%b dbz=%b one cycle later, expected 0 0", name, done, div_by_zero);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; mthi = 0; mtlo = 0; flush = 0; md_op = 0; op_x = 0; op_y = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mul();
    int bc;
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_result("multu_max", -1, bc);
    checks++;
    if (bc != 33) begin failures++; $display("FAIL multu_busy: got %0d cycles expected 33", bc); end
    launch(2'd0, -32'sd3, 32'd7, 1'b0);
    wait_result("mult_neg", -1, bc);
    checks++;
    if (bc != 33) begin failures++; $display("FAIL mult_busy: got %0d cycles expected 33", bc); end
    launch(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_result("mult_minmin", -1, bc);
  endtask

  task automatic test_div();
    int bc;
    launch(2'd2, -32'sd7, 32'd2, 1'b0);
    wait_result("div_neg", -1, bc);
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_result("div_overflow", -1, bc);
    launch(2'd3, 32'hFFFF_FFFF, 32'd7, 1'b0);
    wait_result("divu_big", -1, bc);
    launch(2'd2, 32'd100, -32'sd9, 1'b0);
    wait_result("div_negy", -1, bc);
  endtask

  task automatic test_div_zero();
    int bc;
    launch(2'd3, 32'd100, 32'd0, 1'b0);
    wait_result("divu_zero", -1, bc);
    launch(2'd2, -32'sd5, 32'd0, 1'b0);
    wait_result("div_zero_neg", -1, bc);
  endtask

  task automatic test_mt_flush();
    bit saw_done;
    @(negedge clk); mthi = 1; mtlo = 1; op_x = 32'h1234;
    @(negedge clk); mthi = 0; mtlo = 1; op_x = 32'h5678;
    @(negedge clk); mtlo = 0;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      failures++;
      $display("FAIL mt_write: got hi=%h lo=%h expected 1234 5678", hi, lo);
    end
    @(negedge clk); start = 1; md_op = 2'd1; op_x = 32'hFFFF_FFFF; op_y = 32'hFFFF_FFFF;
    saw_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (done) saw_done = 1;
    end
    flush = 1;
    @(negedge clk); flush = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: busy=%b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin failures++; $display("FAIL flush_done: done seen=1 expected 0"); end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      failures++;
      $display("FAIL flush_hilo: got hi=%h lo=%h expected 1234 5678", hi, lo);
    end
    @(negedge clk); start = 1; flush = 1; md_op = 2'd0; op_x = 3; op_y = 4;
    @(negedge clk); start = 0; flush = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_start: busy=%b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    int bc;
    launch(2'd1, 32'd5, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    launch(2'd3, 32'd1000, 32'd3, 1'b0);
    wait_result("after_reset", -1, bc);
  endtask

  task automatic test_back_to_back();
    int          bc;
    logic [1:0]  op;
    logic [W-1:0] x, y;
    // start with mthi/mtlo together: start wins, HI/LO get only the product
    launch(2'd1, 32'd2, 32'd3, 1'b1);
    wait_result("start_over_mt", -1, bc);
    for (int n = 0; n < 10; n++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      case (n % 3)
        0: y = $urandom;
        1: y = 32'($urandom_range(0, 15));
        default: y = (n == 5) ? 32'd0 : -32'($urandom_range(1, 100));
      endcase
      launch(op, x, y, 1'b0);
      wait_result($sformatf("b2b_%0d", n), int'($urandom_range(2, 20)), bc);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mt_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
